// File: rtl/spi_fb_writer.sv
// SPI word stream to double-buffered framebuffer writer.
// Headers open write/swap transactions; data words become 1-cycle-latency framebuffer writes.
module spi_fb_writer #(
   parameter int ADDR_WIDTH = 11,
   parameter int FB_WORDS   = 2048
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [31:0]           word_in,
   input  logic                  word_valid,
   input  logic                  word_first,
   input  logic                  frame_start,
   output logic                  fb_we,
   output logic [ADDR_WIDTH:0]   fb_waddr,
   output logic [23:0]           fb_wdata,
   output logic                  disp_bank,
   output logic                  swap_pending,
   output logic                  overflow,
   output logic                  proto_err
);

   // One extra bit so FB_WORDS == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH+1)'(FB_WORDS - 1);
   localparam logic [7:0]          CMD_WRITE = 8'h01;
   localparam logic [7:0]          CMD_SWAP  = 8'h02;

   typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic                  wbank, wbank_nxt;
   logic                  we_nxt;
   logic [ADDR_WIDTH:0]   waddr_nxt;
   logic [23:0]           wdata_nxt;
   logic                  swap_set, ovf_set, perr_set;
   logic                  hdr, dat;
   logic [7:0]            cmd;
   logic [ADDR_WIDTH-1:0] start;

   assign hdr   = word_valid & word_first;
   assign dat   = word_valid & ~word_first;
   assign cmd   = word_in[31:24];
   assign start = word_in[ADDR_WIDTH-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      wbank_nxt = wbank;
      we_nxt    = 1'b0;
      waddr_nxt = fb_waddr;
      wdata_nxt = fb_wdata;
      swap_set  = 1'b0;
      ovf_set   = 1'b0;
      perr_set  = 1'b0;
      if (hdr) begin
         // A header always wins, aborting whatever transaction was open.
         case (cmd)
            CMD_WRITE: begin
               if ({1'b0, start} <= LAST_WORD) begin
                  state_nxt = WRITE;
                  addr_nxt  = start;
                  wbank_nxt = ~disp_bank;
               end else begin
                  state_nxt = DISCARD;
                  ovf_set   = 1'b1;
               end
            end
            CMD_SWAP: begin
               swap_set  = 1'b1;
               state_nxt = IDLE;
            end
            default: begin
               perr_set  = 1'b1;
               state_nxt = IDLE;
            end
         endcase
      end else if (dat) begin
         case (state)
            WRITE: begin
               we_nxt    = 1'b1;
               waddr_nxt = {wbank, addr};
               wdata_nxt = word_in[23:0];
               if ({1'b0, addr} == LAST_WORD) state_nxt = DISCARD;
               else                           addr_nxt  = addr + 1'b1;
            end
            DISCARD: ovf_set  = 1'b1;
            default: perr_set = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr      <= '0;
         wbank     <= 1'b1;
         fb_we     <= 1'b0;
         fb_waddr  <= '0;
         fb_wdata  <= '0;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         addr      <= addr_nxt;
         wbank     <= wbank_nxt;
         fb_we     <= we_nxt;
         fb_waddr  <= waddr_nxt;
         fb_wdata  <= wdata_nxt;
         overflow  <= overflow | ovf_set;
         proto_err <= proto_err | perr_set;
      end
   end

   // A swap requested on a frame_start edge waits for the following frame.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disp_bank    <= 1'b0;
         swap_pending <= 1'b0;
      end else begin
         if (frame_start && swap_pending) disp_bank <= ~disp_bank;
         swap_pending <= swap_set | (swap_pending & ~frame_start);
      end
   end

endmodule

// File: doc/spi_fb_writer.md
SPI_FB_WRITER -- requirements
Module: spi_fb_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, giving the per-bank framebuffer word address width.
REQ-002 SHALL have parameter FB_WORDS, default 2048, giving the valid words per bank; FB_WORDS <= 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port word_in  input  32  received SPI word; valid only while word_valid=1.
REQ-006 SHALL have port word_valid  input  1  one-cycle pulse per received word (the SPI satellite's done).
REQ-007 SHALL have port word_first  input  1  qualifies word_valid; marks the first word after CS falling edge.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse from the HUB75E scanner at the start of each display frame.
REQ-009 SHALL have port fb_we  output  1  framebuffer write enable, one-cycle pulse.
REQ-010 SHALL have port fb_waddr  output  ADDR_WIDTH+1  write address; MSB = bank, LSBs = word address.
REQ-011 SHALL have port fb_wdata  output  24  pixel data, RGB888 = word_in[23:0].
REQ-012 SHALL have port disp_bank  output  1  bank currently scanned out by the display.
REQ-013 SHALL have port swap_pending  output  1  a swap is requested and not yet applied.
REQ-014 SHALL have port overflow  output  1  sticky: data word dropped past the end of the bank.
REQ-015 SHALL have port proto_err  output  1  sticky: data word received with no open write transaction, or unknown command.

Function
REQ-016 SHALL treat every word with word_valid=1 and word_first=1 as a header: cmd = word_in[31:24], start = word_in[ADDR_WIDTH-1:0].
REQ-017 SHALL implement states IDLE, WRITE, DISCARD; a header SHALL be accepted in every state and abort any transaction in progress.
REQ-018 On header cmd 0x01 with start < FB_WORDS: SHALL go to WRITE, load addr counter = start, latch wbank = ~disp_bank.
REQ-019 On header cmd 0x01 with start >= FB_WORDS: SHALL go to DISCARD and set overflow.
REQ-020 On header cmd 0x02 (SWAP): SHALL set swap_pending and go to IDLE.
REQ-021 On any other header cmd: SHALL set proto_err and go to IDLE.
REQ-022 In WRITE, each word_valid with word_first=0 SHALL produce, on the next cycle, fb_we=1, fb_waddr={wbank, addr}, fb_wdata=word_in[23:0]; addr SHALL then increment by 1.
REQ-023 After writing addr = FB_WORDS-1, SHALL go to DISCARD; no address wrap-around SHALL occur.
REQ-024 In DISCARD, each data word SHALL be dropped (fb_we=0) and SHALL set overflow.
REQ-025 In IDLE, each data word SHALL be dropped and SHALL set proto_err.
REQ-026 fb_we SHALL be 0 in every cycle not covered by REQ-022; fb_waddr/fb_wdata SHALL hold their last values when fb_we=0.
REQ-027 On frame_start with swap_pending=1: SHALL toggle disp_bank and clear swap_pending on the same edge.
REQ-028 A SWAP header and frame_start in the same cycle: swap_pending SHALL be set and the swap SHALL take effect at the next frame_start, not the current one.
REQ-029 A repeated SWAP while swap_pending=1 SHALL leave it set (no double toggle).
REQ-030 A WRITE transaction open across a bank toggle SHALL keep its latched wbank.
REQ-031 Write latency SHALL be exactly 1 cycle from word_valid to fb_we; back-to-back word_valid pulses in consecutive cycles SHALL be supported.

Reset
REQ-032 resetn=0 SHALL asynchronously force state=IDLE, addr=0, wbank=1, fb_we=0, fb_waddr=0, fb_wdata=0, disp_bank=0, swap_pending=0, overflow=0, proto_err=0.
REQ-033 Reset mid-transaction SHALL discard it; after release, data words before a new header SHALL set proto_err.
REQ-034 overflow and proto_err SHALL clear only on reset.

Verification
REQ-035 Header 0x01000010, then data 0x00FF0000, 0x0000FF00 -> fb_we pulses with fb_waddr 0x810 / 0x811, fb_wdata 0xFF0000 / 0x00FF00, one cycle after each word.
REQ-036 Header 0x010007FE, then 3 data words -> writes at 0xFFE, 0xFFF; third word dropped; overflow=1.
REQ-037 Header 0x02000000, frame_start 5 cycles later -> swap_pending=1 until that edge, then disp_bank=1, swap_pending=0; next WRITE header uses bank 0 (fb_waddr MSB=0).
REQ-038 SWAP header coincident with frame_start -> disp_bank unchanged, swap_pending=1; next frame_start toggles disp_bank.
REQ-039 Data word with no prior header -> no fb_we, proto_err=1; header cmd 0x7F -> proto_err=1, state IDLE.
REQ-040 resetn pulsed low after 2 of 4 data words -> all outputs at REQ-032 values immediately; remaining 2 words produce no fb_we and set proto_err.
